// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, default multiply latency and register-file constants.
package pipeline_pkg;

   // Controller FSM states. RUN is normal issue; MUL_WAIT holds the front
   // end while a multi-cycle ALU op occupies EX.
   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } state_e;

   // Default number of EX-stage cycles a multi-cycle ALU op occupies (2..15).
   localparam int MUL_LAT_DEFAULT = 4;

   // Register $0 is hardwired to zero and never creates a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Saturation ceiling of the stall-cycle counter.
   localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: flags an ID instruction that reads the
// destination of a load currently in EX.
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   output logic       load_use
);

   logic rs_hit;
   logic rt_hit;

   // A source only matters when the instruction actually reads it, and a
   // load into $0 never produces a value anyone can depend on.
   always_comb begin
      rs_hit   = id_uses_rs && (id_rs == ex_rt);
      rt_hit   = id_uses_rt && (id_rt == ex_rt);
      load_use = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller. Resolves memory stalls, multi-cycle ALU
// holds, taken jumps and load-use hazards into per-stage enables, and
// counts cycles in which the PC was held.
//
// Output priority, highest first:
//   reset > MemStall > MUL_WAIT > EX_Jump > EX_MulStart > LoadUse > normal
// Enables are combinational from state and inputs so a hazard is answered
// in the same cycle it is seen; only the FSM, MulCnt and StallCount are
// registered. MulBusy is the FSM state bit made visible.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT
)
(
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UsesRs,
   input  logic        ID_UsesRt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_rt,
   input  logic        EX_Jump,
   input  logic        EX_MulStart,
   input  logic        MemStall,
   output logic        PCWrite,
   output logic        IF_ID_Write,
   output logic        IF_ID_Flush,
   output logic        ID_EX_Write,
   output logic        ID_EX_Bubble,
   output logic        MulBusy,
   output logic [15:0] StallCount
);

   // Hold cycles spent in MUL_WAIT after the first EX cycle of the op.
   localparam logic [3:0] MUL_WAIT_CNT = 4'(MUL_LAT - 2);

   state_e      state_q, state_d;
   logic [3:0]  mul_cnt_q, mul_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        load_use;

   hazard_detect u_hazard_detect (
      .ex_mem_read (EX_MemRead),
      .ex_rt       (EX_rt),
      .id_rs       (ID_rs),
      .id_rt       (ID_rt),
      .id_uses_rs  (ID_UsesRs),
      .id_uses_rt  (ID_UsesRt),
      .load_use    (load_use)
   );

   // Priority mux for stage enables plus FSM/MulCnt next-state logic.
   always_comb begin
      state_d      = state_q;
      mul_cnt_d    = mul_cnt_q;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;

      if (!Rst_n) begin
         // Pipeline registers are cleared and nothing advances while in reset.
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (MemStall) begin
         // Whole pipeline frozen; FSM and MulCnt keep their values.
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Write = 1'b0;
      end else if (state_q == MUL_WAIT) begin
         // Jumps and new mul starts are ignored here: EX is still busy.
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Write = 1'b0;
         mul_cnt_d   = mul_cnt_q - 4'd1;
         if (mul_cnt_q <= 4'd1) begin
            state_d = RUN;
         end
      end else if (EX_Jump) begin
         // Squash the two younger slots in IF/ID and ID/EX, no extra stall.
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (EX_MulStart) begin
         // First EX cycle of the op already holds; MUL_LAT=2 needs no more.
         PCWrite     = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Write = 1'b0;
         if (MUL_LAT > 2) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_WAIT_CNT;
         end
      end else if (load_use) begin
         // Hold IF/ID one cycle; the bubble clears EX_MemRead next cycle.
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

   // Saturating count of post-reset cycles in which the PC was held.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PCWrite && (stall_cnt_q != STALL_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State, MulCnt and StallCount registers; reset abandons any mul hold.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= RUN;
         mul_cnt_q   <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         mul_cnt_q   <= mul_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign MulBusy    = (state_q == MUL_WAIT);
   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: table of single-cycle hazard vectors followed by
// hand-written multi-cycle sequences (mul hold, stall inside mul, reset
// inside mul). Output word order: {PCWrite, IF_ID_Write, IF_ID_Flush,
// ID_EX_Write, ID_EX_Bubble, MulBusy}.
module tb_pipeline_ctrl;

   localparam logic [5:0] O_NORMAL = 6'b110100;
   localparam logic [5:0] O_LOADUSE = 6'b000110;
   localparam logic [5:0] O_JUMP = 6'b111110;
   localparam logic [5:0] O_HOLD = 6'b000000;
   localparam logic [5:0] O_BUSY = 6'b000001;
   localparam logic [5:0] O_RESET = 6'b001010;

   logic        Clk;
   logic        Rst_n;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_UsesRs;
   logic        ID_UsesRt;
   logic        EX_MemRead;
   logic [4:0]  EX_rt;
   logic        EX_Jump;
   logic        EX_MulStart;
   logic        MemStall;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Write;
   logic        ID_EX_Bubble;
   logic        MulBusy;
   logic [15:0] StallCount;

   logic [5:0]  outs;
   assign outs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, MulBusy};

   pipeline_ctrl #(.MUL_LAT(4)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .ID_rs        (ID_rs),
      .ID_rt        (ID_rt),
      .ID_UsesRs    (ID_UsesRs),
      .ID_UsesRt    (ID_UsesRt),
      .EX_MemRead   (EX_MemRead),
      .EX_rt        (EX_rt),
      .EX_Jump      (EX_Jump),
      .EX_MulStart  (EX_MulStart),
      .MemStall     (MemStall),
      .PCWrite      (PCWrite),
      .IF_ID_Write  (IF_ID_Write),
      .IF_ID_Flush  (IF_ID_Flush),
      .ID_EX_Write  (ID_EX_Write),
      .ID_EX_Bubble (ID_EX_Bubble),
      .MulBusy      (MulBusy),
      .StallCount   (StallCount)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- scoreboard state ----------------
   logic [5:0]  exp_q[$];
   logic [15:0] exp_stall;
   int          n_checks;
   int          n_fail;

   typedef struct {
      logic       mem_read;
      logic [4:0] ex_rt;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       uses_rs;
      logic       uses_rt;
      logic       jump;
      logic       mem_stall;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      ID_rs       = 5'd0;
      ID_rt       = 5'd0;
      ID_UsesRs   = 1'b0;
      ID_UsesRt   = 1'b0;
      EX_MemRead  = 1'b0;
      EX_rt       = 5'd0;
      EX_Jump     = 1'b0;
      EX_MulStart = 1'b0;
      MemStall    = 1'b0;
   endtask

   task automatic drive_vec(input vec_t v);
      EX_MemRead  = v.mem_read;
      EX_rt       = v.ex_rt;
      ID_rs       = v.id_rs;
      ID_rt       = v.id_rt;
      ID_UsesRs   = v.uses_rs;
      ID_UsesRt   = v.uses_rt;
      EX_Jump     = v.jump;
      EX_MulStart = 1'b0;
      MemStall    = v.mem_stall;
   endtask

   // Sample mid-cycle against the expected word, then advance one clock.
   // The stall model counts every out-of-reset cycle whose expected PCWrite is 0.
   task automatic run_cycle(input string name, input logic [5:0] exp);
      logic [5:0] e;
      exp_q.push_back(exp);
      @(negedge Clk);
      e = exp_q.pop_front();
      check_val({name, " outs"}, {10'd0, outs}, {10'd0, e});
      check_val({name, " stall_cnt"}, StallCount, exp_stall);
      if (!e[5]) exp_stall = exp_stall + 16'd1;
      @(posedge Clk);
      #1;
   endtask

   function automatic vec_t mk(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urs, input logic urt,
                               input logic jmp, input logic ms, input logic [5:0] exp);
      vec_t v;
      v.mem_read = mr;  v.ex_rt = ert;  v.id_rs = rs;  v.id_rt = rt;
      v.uses_rs = urs;  v.uses_rt = urt;  v.jump = jmp;  v.mem_stall = ms;
      v.exp = exp;
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      exp_stall = 16'd0;
      Rst_n     = 1'b0;
      drive_idle();

      //            mr  ert    rs     rt     urs  urt  jmp  ms   expected
      vecs[0]  = mk(1, 5'd5,  5'd5,  5'd7,  1,   1,   0,   0,   O_LOADUSE); // lw $5 then add rs=$5
      vecs[1]  = mk(1, 5'd0,  5'd0,  5'd0,  1,   1,   0,   0,   O_NORMAL);  // load into $0
      vecs[2]  = mk(1, 5'd9,  5'd3,  5'd9,  1,   1,   0,   0,   O_LOADUSE); // rt match
      vecs[3]  = mk(1, 5'd9,  5'd9,  5'd2,  0,   1,   0,   0,   O_NORMAL);  // rs match, not read
      vecs[4]  = mk(1, 5'd9,  5'd2,  5'd9,  1,   0,   0,   0,   O_NORMAL);  // rt match, not read
      vecs[5]  = mk(0, 5'd9,  5'd9,  5'd9,  1,   1,   0,   0,   O_NORMAL);  // not a load
      vecs[6]  = mk(1, 5'd5,  5'd5,  5'd0,  1,   0,   1,   0,   O_JUMP);    // jump beats load-use
      vecs[7]  = mk(0, 5'd0,  5'd1,  5'd2,  1,   1,   1,   0,   O_JUMP);    // plain jump
      vecs[8]  = mk(1, 5'd5,  5'd5,  5'd0,  1,   0,   0,   1,   O_HOLD);    // mem stall beats load-use
      vecs[9]  = mk(0, 5'd0,  5'd0,  5'd0,  0,   0,   1,   1,   O_HOLD);    // mem stall beats jump
      vecs[10] = mk(1, 5'd31, 5'd31, 5'd31, 1,   1,   0,   0,   O_LOADUSE); // top register
      vecs[11] = mk(1, 5'd4,  5'd5,  5'd6,  1,   1,   0,   0,   O_NORMAL);  // no match

      // Reset state, then release just after an edge.
      @(negedge Clk);
      check_val("reset outs", {10'd0, outs}, {10'd0, O_RESET});
      check_val("reset stall_cnt", StallCount, 16'd0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 12; i++) begin
         drive_vec(vecs[i]);
         run_cycle($sformatf("vec%0d", i), vecs[i].exp);
      end
      drive_idle();
      run_cycle("after table", O_NORMAL);

      // Multi-cycle op, MUL_LAT=4: three hold cycles, busy on the last two.
      // Jump and a new start during MUL_WAIT must be ignored.
      EX_MulStart = 1'b1;
      run_cycle("mul start", O_HOLD);
      EX_MulStart = 1'b0;
      EX_Jump     = 1'b1;
      run_cycle("mul wait1 jump ignored", O_BUSY);
      EX_Jump     = 1'b0;
      EX_MulStart = 1'b1;
      run_cycle("mul wait2 start ignored", O_BUSY);
      EX_MulStart = 1'b0;
      run_cycle("mul done", O_NORMAL);

      // Memory stall for two cycles while MulCnt=1: total hold of five.
      EX_MulStart = 1'b1;
      run_cycle("ms mul start", O_HOLD);
      EX_MulStart = 1'b0;
      run_cycle("ms wait cnt2", O_BUSY);
      MemStall = 1'b1;
      run_cycle("ms frozen1", O_BUSY);
      run_cycle("ms frozen2", O_BUSY);
      MemStall = 1'b0;
      run_cycle("ms wait cnt1", O_BUSY);
      run_cycle("ms done", O_NORMAL);

      // Reset mid MUL_WAIT: busy drops without a clock, counter clears.
      EX_MulStart = 1'b1;
      run_cycle("rst mul start", O_HOLD);
      EX_MulStart = 1'b0;
      run_cycle("rst wait cnt2", O_BUSY);
      #2;
      Rst_n = 1'b0;
      #1;
      exp_stall = 16'd0;
      check_val("async rst outs", {10'd0, outs}, {10'd0, O_RESET});
      check_val("async rst stall_cnt", StallCount, 16'd0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      run_cycle("post rst run", O_NORMAL);
      EX_MemRead = 1'b1;
      EX_rt      = 5'd12;
      ID_rt      = 5'd12;
      ID_UsesRt  = 1'b1;
      run_cycle("post rst loaduse", O_LOADUSE);
      drive_idle();
      run_cycle("final", O_NORMAL);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4, range 2..15: EX-stage cycles occupied by a multi-cycle ALU op.
REQ-002 SHALL have ports, one per line: name direction width meaning.
  Clk  in  1  single clock, rising edge.
  Rst_n  in  1  asynchronous active-low reset.
  ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
  ID_UsesRs, ID_UsesRt  in  1 each  ID instruction reads that source.
  EX_MemRead  in  1  MemReadOut of ID_EX.
  EX_rt  in  5  rtOut of ID_EX (load destination).
  EX_Jump  in  1  jump/jr resolved taken in EX.
  EX_MulStart  in  1  EX holds a multi-cycle ALU op in its first EX cycle.
  MemStall  in  1  data memory not ready; freezes whole pipeline.
  PCWrite  out  1  PC load enable.
  IF_ID_Write  out  1  IF/ID load enable.
  IF_ID_Flush  out  1  IF/ID zeroed on next edge.
  ID_EX_Write  out  1  ID/EX load enable.
  ID_EX_Bubble  out  1  ID/EX control fields zeroed on next edge.
  MulBusy  out  1  FSM in MUL_WAIT.
  StallCount  out  16  saturating count of cycles with PCWrite=0 outside reset.

Function
REQ-003 SHALL implement FSM states RUN and MUL_WAIT, plus a 4-bit down-counter MulCnt.
REQ-004 SHALL, in RUN, compute LoadUse = EX_MemRead & (EX_rt != 0) & ((ID_UsesRs & ID_rs == EX_rt) | (ID_UsesRt & ID_rt == EX_rt)).
REQ-005 SHALL resolve outputs with priority, highest first: MemStall > MUL_WAIT > EX_Jump > EX_MulStart > LoadUse > normal.
REQ-006 SHALL, on MemStall=1 in any state: PCWrite=IF_ID_Write=ID_EX_Write=0, flush/bubble=0; FSM state and MulCnt frozen.
REQ-007 SHALL, in MUL_WAIT: PCWrite=IF_ID_Write=ID_EX_Write=0, MulBusy=1; MulCnt decrements each non-stalled cycle; MulCnt==1 -> RUN next cycle.
REQ-008 SHALL, on EX_Jump in RUN: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Write=1, ID_EX_Bubble=1 (two squashed slots, zero extra stall).
REQ-009 SHALL, on EX_MulStart in RUN with no jump: the same outputs as MUL_WAIT for this cycle; next state MUL_WAIT with MulCnt=MUL_LAT-2; MUL_LAT=2 stays in RUN (one hold cycle only).
REQ-010 SHALL, on LoadUse in RUN with no jump or mul: PCWrite=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Bubble=1, for exactly one cycle (bubble clears EX_MemRead).
REQ-011 SHALL, otherwise, drive PCWrite=IF_ID_Write=ID_EX_Write=1, flush/bubble=0.
REQ-012 SHALL derive all enable/flush outputs combinationally from state and inputs (same-cycle response); only state, MulCnt and StallCount are registered.
REQ-013 SHALL increment StallCount on each non-reset cycle with PCWrite=0, saturating at 16'hFFFF.
REQ-014 SHALL ignore EX_Jump and EX_MulStart while in MUL_WAIT.

Reset
REQ-015 SHALL, while Rst_n=0: state=RUN, MulCnt=0, StallCount=0, MulBusy=0, PCWrite=IF_ID_Write=ID_EX_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1.
REQ-016 SHALL abandon MUL_WAIT immediately on reset assertion mid-operation, and resume in RUN on the first edge after release.

Structure
REQ-017 SHALL place state encoding (RUN=1'b0, MUL_WAIT=1'b1) and the default MUL_LAT in a shared package pipeline_pkg.
REQ-018 SHALL factor hazard compare (REQ-004) into sub-module hazard_detect; FSM, counters and priority mux stay in pipeline_ctrl.

Verification
REQ-019 SHALL cover: lw $5 in EX (EX_MemRead=1, EX_rt=5), ID add uses rs=5 -> one cycle PCWrite=0, ID_EX_Bubble=1, StallCount 0->1.
REQ-020 SHALL cover: EX_rt=0 with EX_MemRead=1, rs=0 -> no stall, PCWrite=1.
REQ-021 SHALL cover: EX_MulStart=1, MUL_LAT=4 -> PCWrite=0 for exactly 3 cycles, MulBusy=1 for the last 2, then RUN.
REQ-022 SHALL cover: EX_Jump=1 and LoadUse same cycle -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, no stall.
REQ-023 SHALL cover: MemStall=1 for 2 cycles mid MUL_WAIT (MulCnt=1) -> MulCnt frozen, total hold = 5 cycles, StallCount +5.
REQ-024 SHALL cover: Rst_n pulled low in MUL_WAIT -> MulBusy=0 asynchronously, StallCount=0, RUN after release.
